// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the five-stage LC-3b pipeline (optional counters: PIPE_CTRL_PERF_EN).
// Latency: all enables/flushes/requests are combinational from inputs plus if_done/me_done; counters lag one cycle.
// Backpressure: the whole pipe holds until both fetch and data handshakes are complete; load-use stalls PC and IF/ID only.
module pipe_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        icache_resp,
   input  logic        dcache_resp,
   input  logic        me_mem_read,
   input  logic        me_mem_write,
   input  logic        me_br_taken,
   input  logic        ex_is_load,
   input  logic [2:0]  ex_dest,
   input  logic [2:0]  id_src1,
   input  logic [2:0]  id_src2,
   input  logic        id_uses_src1,
   input  logic        id_uses_src2,
   output logic        icache_read,
   output logic        dcache_read,
   output logic        dcache_write,
   output logic        load_pc,
   output logic        load_ifid,
   output logic        load_idex,
   output logic        load_exme,
   output logic        load_mewb,
   output logic        pc_sel,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        flush_exme,
   output logic [15:0] stall_cycles,
   output logic [15:0] bubbles
);

   logic if_done;
   logic me_done;
   logic fetch_ok;
   logic mem_ok;
   logic advance;
   logic load_use;

   // Handshake qualification; reset masks advance so a late response in the reset cycle is ignored
   always_comb begin
      fetch_ok = icache_resp | if_done;
      mem_ok   = !(me_mem_read | me_mem_write) | dcache_resp | me_done;
      advance  = !reset & fetch_ok & mem_ok;
      load_use = ex_is_load &
                 ((id_uses_src1 & (id_src1 == ex_dest)) |
                  (id_uses_src2 & (id_src2 == ex_dest)));
   end

   // Sticky completion flags: set by a response, cleared by any advance (clear wins)
   always_ff @(posedge clk) begin
      if (reset) begin
         if_done <= 1'b0;
         me_done <= 1'b0;
      end else if (advance) begin
         if_done <= 1'b0;
         me_done <= 1'b0;
      end else begin
         if (icache_resp) if_done <= 1'b1;
         if (dcache_resp) me_done <= 1'b1;
      end
   end

   // Cache requests and pipe register enables; redirect outranks load-use
   always_comb begin
      icache_read  = 1'b0;
      dcache_read  = 1'b0;
      dcache_write = 1'b0;
      load_pc      = 1'b0;
      load_ifid    = 1'b0;
      load_idex    = 1'b0;
      load_exme    = 1'b0;
      load_mewb    = 1'b0;
      pc_sel       = 1'b0;
      flush_ifid   = 1'b0;
      flush_idex   = 1'b0;
      flush_exme   = 1'b0;
      if (!reset) begin
         icache_read  = !if_done;
         dcache_read  = me_mem_read & !me_done;
         dcache_write = me_mem_write & !me_done;
      end
      if (advance) begin
         load_idex = 1'b1;
         load_exme = 1'b1;
         load_mewb = 1'b1;
         if (me_br_taken) begin
            load_pc    = 1'b1;
            load_ifid  = 1'b1;
            pc_sel     = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            flush_exme = 1'b1;
         end else if (load_use) begin
            flush_idex = 1'b1;
         end else begin
            load_pc   = 1'b1;
            load_ifid = 1'b1;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] stall_q;
   logic [15:0] bubble_q;
   logic        bubble_now;

   assign bubble_now   = advance & (me_br_taken | load_use);
   assign stall_cycles = stall_q;
   assign bubbles      = bubble_q;

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q  <= 16'd0;
         bubble_q <= 16'd0;
      end else begin
         if (!advance && stall_q != 16'hFFFF)     stall_q  <= stall_q + 16'd1;
         if (bubble_now && bubble_q != 16'hFFFF)  bubble_q <= bubble_q + 16'd1;
      end
   end
`else
   assign stall_cycles = 16'd0;
   assign bubbles      = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random traffic.
// Expected values come from a transaction-level model of the fetch/data handshakes.
// Counters are expected only when PIPE_CTRL_PERF_EN is defined, otherwise zero.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        icache_resp, dcache_resp;
   logic        me_mem_read, me_mem_write, me_br_taken;
   logic        ex_is_load;
   logic [2:0]  ex_dest, id_src1, id_src2;
   logic        id_uses_src1, id_uses_src2;
   logic        icache_read, dcache_read, dcache_write;
   logic        load_pc, load_ifid, load_idex, load_exme, load_mewb;
   logic        pc_sel, flush_ifid, flush_idex, flush_exme;
   logic [15:0] stall_cycles, bubbles;

   int errors = 0;
   int checks = 0;

   // Model state: has the fetch / data access of the current instruction slot completed?
   bit fetch_seen;
   bit data_seen;
   int stall_cnt;
   int bubble_cnt;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .reset(reset),
      .icache_resp(icache_resp), .dcache_resp(dcache_resp),
      .me_mem_read(me_mem_read), .me_mem_write(me_mem_write), .me_br_taken(me_br_taken),
      .ex_is_load(ex_is_load), .ex_dest(ex_dest),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
      .icache_read(icache_read), .dcache_read(dcache_read), .dcache_write(dcache_write),
      .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
      .load_exme(load_exme), .load_mewb(load_mewb), .pc_sel(pc_sel),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exme(flush_exme),
      .stall_cycles(stall_cycles), .bubbles(bubbles)
   );

   function automatic bit hazard();
      bit r1, r2;
      r1 = id_uses_src1 && (id_src1 == ex_dest);
      r2 = id_uses_src2 && (id_src2 == ex_dest);
      return ex_is_load && (r1 || r2);
   endfunction

   function automatic bit will_advance();
      bit fetched, data_ready;
      fetched    = icache_resp || fetch_seen;
      data_ready = !(me_mem_read || me_mem_write) || dcache_resp || data_seen;
      return !reset && fetched && data_ready;
   endfunction

   task automatic idle_inputs();
      icache_resp  = 1'b0; dcache_resp  = 1'b0;
      me_mem_read  = 1'b0; me_mem_write = 1'b0; me_br_taken = 1'b0;
      ex_is_load   = 1'b0; ex_dest      = 3'd0;
      id_src1      = 3'd0; id_src2      = 3'd0;
      id_uses_src1 = 1'b0; id_uses_src2 = 1'b0;
   endtask

   // Compare one cycle mid-period against the model, then advance the model at the clock edge
   task automatic cycle(input string tag);
      logic [2:0]  exp_req, got_req;
      logic [8:0]  exp_ctl, got_ctl;
      logic [31:0] exp_cnt, got_cnt;
      bit adv;
      @(negedge clk);
      adv = will_advance();
      if (reset) exp_req = 3'b000;
      else exp_req = {!fetch_seen, me_mem_read && !data_seen, me_mem_write && !data_seen};
      // {load_pc, load_ifid, load_idex, load_exme, load_mewb, pc_sel, flush_ifid, flush_idex, flush_exme}
      if (!adv)              exp_ctl = 9'b00000_0_000;
      else if (me_br_taken)  exp_ctl = 9'b11111_1_111;
      else if (hazard())     exp_ctl = 9'b00111_0_010;
      else                   exp_ctl = 9'b11111_0_000;
      exp_cnt = PERF ? {stall_cnt[15:0], bubble_cnt[15:0]} : 32'd0;
      got_req = {icache_read, dcache_read, dcache_write};
      got_ctl = {load_pc, load_ifid, load_idex, load_exme, load_mewb,
                 pc_sel, flush_ifid, flush_idex, flush_exme};
      got_cnt = {stall_cycles, bubbles};
      checks++;
      assert (got_req === exp_req) else begin
         errors++;
         $error("FAIL %s req: observed %b expected %b", tag, got_req, exp_req);
      end
      checks++;
      assert (got_ctl === exp_ctl) else begin
         errors++;
         $error("FAIL %s ctl: observed %b expected %b", tag, got_ctl, exp_ctl);
      end
      checks++;
      assert (got_cnt === exp_cnt) else begin
         errors++;
         $error("FAIL %s cnt: observed %h expected %h", tag, got_cnt, exp_cnt);
      end
      @(posedge clk);
      if (reset) begin
         fetch_seen = 0; data_seen = 0; stall_cnt = 0; bubble_cnt = 0;
      end else begin
         if (!adv && stall_cnt < 65535) stall_cnt++;
         if (adv && (me_br_taken || hazard()) && bubble_cnt < 65535) bubble_cnt++;
         if (adv) begin
            fetch_seen = 0; data_seen = 0;
         end else begin
            if (icache_resp) fetch_seen = 1;
            if (dcache_resp) data_seen = 1;
         end
      end
      #1;
   endtask

   initial begin
      fetch_seen = 0; data_seen = 0; stall_cnt = 0; bubble_cnt = 0;
      idle_inputs();
      reset = 1'b1;
      #1;
      cycle("reset0");
      icache_resp = 1'b1;            // late response during reset must be ignored
      cycle("reset_resp");
      reset = 1'b0;
      icache_resp = 1'b0;
      cycle("first_after_reset");    // icache_read=1, no advance

      // Zero-wait caches, four independent ADDs
      for (int i = 0; i < 4; i++) begin
         icache_resp = 1'b1;
         id_src1 = 3'(i); id_uses_src1 = 1'b1; ex_dest = 3'd7;
         cycle("zero_wait");
      end
      idle_inputs();

      // Fetch latency 3: two stall cycles then advance
      cycle("ifetch_wait1");
      cycle("ifetch_wait2");
      icache_resp = 1'b1;
      cycle("ifetch_resp");
      idle_inputs();

      // Data resp at cycle 1, fetch resp at cycle 4
      me_mem_read = 1'b1;
      cycle("mem_c0");
      dcache_resp = 1'b1;
      cycle("mem_c1");
      dcache_resp = 1'b0;
      cycle("mem_c2");
      cycle("mem_c3");
      icache_resp = 1'b1;
      cycle("mem_c4");
      idle_inputs();

      // Load-use: LDR R1 in EX, ADD R2,R1,R3 in ID
      icache_resp = 1'b1;
      ex_is_load = 1'b1; ex_dest = 3'd1;
      id_src1 = 3'd1; id_uses_src1 = 1'b1; id_src2 = 3'd3; id_uses_src2 = 1'b1;
      cycle("load_use");
      ex_is_load = 1'b0;
      cycle("after_load_use");
      // Matching src2 that is not read: no stall
      ex_is_load = 1'b1; id_src1 = 3'd4; id_src2 = 3'd1; id_uses_src2 = 1'b0;
      cycle("unused_src2");
      // R0 destination still stalls
      ex_dest = 3'd0; id_src2 = 3'd0; id_uses_src2 = 1'b1;
      cycle("load_use_r0");
      // Redirect with load-use present
      ex_dest = 3'd1; id_src1 = 3'd1; id_uses_src1 = 1'b1;
      me_br_taken = 1'b1;
      cycle("redirect");
      idle_inputs();

      // Reset while a data read is pending, with a response arriving in the reset cycle
      me_mem_read = 1'b1;
      cycle("pend0");
      reset = 1'b1; dcache_resp = 1'b1;
      cycle("pend_reset");
      reset = 1'b0; dcache_resp = 1'b0; icache_resp = 1'b1;
      cycle("pend_after");
      icache_resp = 1'b0;
      cycle("pend_after2");
      idle_inputs();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset        = ($urandom_range(0, 39) == 0);
         icache_resp  = ($urandom_range(0, 2) == 0);
         dcache_resp  = ($urandom_range(0, 2) == 0);
         me_mem_read  = ($urandom_range(0, 3) == 0);
         me_mem_write = !me_mem_read && ($urandom_range(0, 4) == 0);
         me_br_taken  = ($urandom_range(0, 7) == 0);
         ex_is_load   = $urandom_range(0, 1);
         ex_dest      = 3'($urandom_range(0, 7));
         id_src1      = 3'($urandom_range(0, 7));
         id_src2      = 3'($urandom_range(0, 7));
         id_uses_src1 = $urandom_range(0, 1);
         id_uses_src2 = $urandom_range(0, 1);
         cycle("random");
      end
      reset = 1'b0;
      idle_inputs();
      cycle("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
